// File: rtl/reg_bank_sb.sv
// Register bank with x0 hardwired to zero, async clear, optional write-to-read
// bypass and a per-register pending bit used by decode for RAW hazard stalls.
module reg_bank_sb #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 5,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we3,
  input  logic [SIZE-1:0]  A1,
  input  logic [SIZE-1:0]  A2,
  input  logic [SIZE-1:0]  A3,
  input  logic [WIDTH-1:0] WD3,
  input  logic             use1,
  input  logic             use2,
  input  logic             rsv,
  input  logic [SIZE-1:0]  Ar,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic             busy1,
  output logic             busy2,
  output logic             stall,
  output logic [SIZE:0]    pend_cnt
);

  localparam int NREG = 2 ** SIZE;
  localparam logic [SIZE:0] CNT_ONE = (SIZE + 1)'(1);
  localparam bit BYP_EN = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]  pend_q;
  logic [NREG-1:0]  pend_d;
  logic [SIZE:0]    cnt_q;
  logic [SIZE:0]    cnt_d;

  logic wr_en;
  logic rsv_en;
  logic cnt_inc;
  logic cnt_dec;
  logic byp1;
  logic byp2;

  assign wr_en  = we3 && (A3 != '0);
  assign rsv_en = rsv && (Ar != '0);

  // Reserve is applied after release so a newer producer keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[A3] = 1'b0;
    end
    if (rsv_en) begin
      pend_d[Ar] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Incremental popcount: only bits that actually flip move the count.
  always_comb begin
    cnt_inc = rsv_en && !pend_q[Ar];
    cnt_dec = wr_en && pend_q[A3] && !(rsv_en && (Ar == A3));
    cnt_d   = cnt_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!cnt_inc && cnt_dec) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        regs_q[A3] <= WD3;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byp1 = BYP_EN && we3 && (A3 == A1) && (A1 != '0);
  assign byp2 = BYP_EN && we3 && (A3 == A2) && (A2 != '0);

  // Outputs are gated by rst so a bypassed write cannot leak during reset.
  always_comb begin
    RD1 = '0;
    if (!rst && (A1 != '0)) begin
      RD1 = byp1 ? WD3 : regs_q[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (!rst && (A2 != '0)) begin
      RD2 = byp2 ? WD3 : regs_q[A2];
    end
  end

  assign busy1    = !rst && pend_q[A1] && !byp1;
  assign busy2    = !rst && pend_q[A2] && !byp2;
  assign stall    = (use1 && busy1) || (use2 && busy2);
  assign pend_cnt = cnt_q;

endmodule
